// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if
//   Request/response bus between the pipeline (master) and the data-memory
//   access controller (slave).
//
//   Handshake: a request transfers on a rising clock edge where
//   req_valid && req_ready. req_ready is high only while the controller is
//   idle. The master must hold req_valid and all req_* fields stable until
//   that edge. resp_valid is a single-cycle completion pulse with no
//   backpressure. resp_err and resp_rdata are meaningful only while
//   resp_valid is high.
//
//   Signals:
//     req_valid / req_ready   request handshake
//     req_we                  1 = store, 0 = load
//     req_size                00 byte, 01 halfword, 10 word, 11 illegal
//     req_signed              load extension: 1 sign, 0 zero
//     req_addr                byte address
//     req_wdata               store data, right-aligned
//     resp_valid              completion pulse
//     resp_err                misaligned or illegal-size request
//     resp_rdata              extended load data, 0 for stores and errors
interface dmem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Initiator-side controller for a word-addressed data RAM. Accepts byte,
//   halfword and word loads/stores on a byte address, performs
//   read-modify-write for sub-word stores, extends load data and flags
//   misaligned or illegal-size requests.
//
//   Ports:
//     clk, rst_n   clock (rising edge), synchronous active-low reset
//     bus          request/response interface (slave side)
//     mem_we       RAM write enable (only in WRITE, gated by rst_n)
//     mem_addr     RAM word index, addr_q[BUS_WIDTH+1:2] while busy
//     mem_wdata    RAM write data (merged word for sub-word stores)
//     mem_rdata    RAM combinational read data
//     dbg_state    current FSM state
module dmem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_access_ctrl_if.slave     bus,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Only the bits that select a word and a lane within it are kept;
  // higher address bits wrap modulo the RAM size.
  localparam int AW = BUS_WIDTH + 2;

  logic [2:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic req_err;
  logic unused_upper_addr;

  assign unused_upper_addr = ^bus.req_addr[ADDR_WIDTH-1:AW];

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      SZ_HALF: req_err = bus.req_addr[0];
      SZ_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
      SZ_BYTE: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr[AW-1:0];
          wdata_d  = bus.req_wdata;
          if (req_err)
            state_d = ST_ERR;
          else if (bus.req_we && bus.req_size == SZ_WORD)
            state_d = ST_WRITE;
          else
            state_d = ST_READ; // loads, and the read half of sub-word RMW
        end
      end
      ST_READ: begin
        rdata_d = mem_rdata;
        state_d = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Load-side lane selection and extension (little-endian lanes).
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  // Store-side byte enables and replicated data for the merge.
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_rep;
  logic [DATA_WIDTH-1:0] st_word;

  always_comb begin
    rd_shift = rdata_q >> {addr_q[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      SZ_BYTE: ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = rdata_q;
    endcase

    case (size_q)
      SZ_BYTE: begin
        st_be  = 4'b0001 << addr_q[1:0];
        st_rep = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        st_be  = addr_q[1] ? 4'b1100 : 4'b0011;
        st_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be  = 4'b1111;
        st_rep = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++)
      st_word[i*8 +: 8] = st_be[i] ? st_rep[i*8 +: 8] : rdata_q[i*8 +: 8];
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign bus.resp_err   = (state_q == ST_ERR);
  assign bus.resp_rdata = (state_q == ST_RESP && !we_q) ? ld_ext : '0;

  // rst_n gating keeps a reset edge that lands in WRITE from writing.
  assign mem_we    = (state_q == ST_WRITE) && rst_n;
  assign mem_addr  = (state_q != ST_IDLE) ? addr_q[AW-1:2] : '0;
  assign mem_wdata = (state_q == ST_WRITE) ? st_word : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dmem_access_ctrl #(.DATA_WIDTH(32), .BUS_WIDTH(6), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // RAM model with write/handshake bookkeeping
  logic [31:0] ram [64];
  int          we_count = 0;
  int          acc_count = 0;
  int          rsp_count = 0;
  logic [5:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_count      <= we_count + 1;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
    end
    if (bus.req_valid && bus.req_ready) acc_count <= acc_count + 1;
    if (bus.resp_valid) rsp_count <= rsp_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid  = 1'b0;
  endtask

  // Full transaction: latency counted in edges from the accept edge.
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    issue(we, size, sgn, addr, wdata);
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, exp_err});
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    step();
    check({tag, "_pulse"}, {31'b0, bus.resp_valid}, 32'd0);
  endtask

  int w0, a0, r0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Power-on reset
    rst_n = 1'b0;
    step(); step();
    check("rst_ready",      {31'b0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_mem_we",     {31'b0, mem_we},         32'd0);
    check("rst_mem_addr",   {26'b0, mem_addr},       32'd0);
    check("rst_mem_wdata",  mem_wdata,               32'd0);
    check("rst_state",      {29'b0, dbg_state},      32'd0);
    rst_n = 1'b1;
    step();

    // Word store then signed word load
    w0 = we_count;
    txn("st_word", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    check("st_word_wecnt", we_count - w0, 32'd1);
    check("st_word_waddr", {26'b0, last_waddr}, 32'd2);
    check("st_word_wdata", last_wdata, 32'hDEADBEEF);
    txn("ld_word", 1'b0, 2'b10, 1'b1, 32'h08, 32'h0, 2, 1'b0, 32'hDEADBEEF);

    // Byte store into word 2 = 0x11223344; upper wdata bits must be ignored
    txn("st_w2", 1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 2, 1'b0, 32'h0);
    w0 = we_count;
    txn("st_byte", 1'b1, 2'b00, 1'b0, 32'h0A, 32'hFFFFFFAB, 3, 1'b0, 32'h0);
    check("st_byte_wecnt", we_count - w0, 32'd1);
    check("st_byte_ram", ram[2], 32'h11AB3344);

    // Sub-word loads
    txn("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h0A, 32'h0, 2, 1'b0, 32'hFFFFFFAB);
    txn("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, 2, 1'b0, 32'h000000AB);
    txn("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 2, 1'b0, 32'h000011AB);
    txn("ld_byte0", 1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 2, 1'b0, 32'h00000044);

    // Halfword store into the low half, then signed load of it
    txn("st_half", 1'b1, 2'b01, 1'b0, 32'h08, 32'h0000BEEF, 3, 1'b0, 32'h0);
    check("st_half_ram", ram[2], 32'h11ABBEEF);
    txn("ld_shalf_lo", 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 2, 1'b0, 32'hFFFFBEEF);
    txn("ld_uhalf_lo", 1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 2, 1'b0, 32'h0000BEEF);

    // Error responses
    w0 = we_count;
    txn("err_word", 1'b0, 2'b10, 1'b1, 32'h06, 32'h0, 1, 1'b1, 32'h0);
    txn("err_size", 1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678, 1, 1'b1, 32'h0);
    txn("err_half", 1'b1, 2'b01, 1'b0, 32'h09, 32'h00001234, 1, 1'b1, 32'h0);
    check("err_wecnt", we_count - w0, 32'd0);
    check("err_ram", ram[2], 32'h11ABBEEF);

    // Address wrap: 0x100 maps to word 0
    txn("st_wrap", 1'b1, 2'b10, 1'b0, 32'h100, 32'h5A5A5A5A, 2, 1'b0, 32'h0);
    check("st_wrap_waddr", {26'b0, last_waddr}, 32'd0);
    check("st_wrap_ram", ram[0], 32'h5A5A5A5A);

    // Continuous req_valid: one accept per 3-cycle load
    a0 = acc_count;
    r0 = rsp_count;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h0;
    bus.req_valid  = 1'b1;
    repeat (9) step();
    bus.req_valid  = 1'b0;
    repeat (3) step();
    check("bp_accepts", acc_count - a0, 32'd3);
    check("bp_resps",   rsp_count - r0, 32'd3);

    // Reset in the WRITE state of a sub-word store
    txn("st_w3", 1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D, 2, 1'b0, 32'h0);
    w0 = we_count;
    r0 = rsp_count;
    issue(1'b1, 2'b00, 1'b0, 32'h0C, 32'h00000077);
    check("mid_state_read", {29'b0, dbg_state}, 32'd1);
    step();
    check("mid_we_in_write", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we_gated", {31'b0, mem_we}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    check("mid_ready",      {31'b0, bus.req_ready},  32'd1);
    check("mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    repeat (3) step();
    check("mid_no_resp",  rsp_count - r0, 32'd0);
    check("mid_no_write", we_count - w0,  32'd0);
    check("mid_ram",      ram[3], 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Initiator-side controller for the word-addressed data RAM. It accepts byte, halfword and word load/store requests from the pipeline on a byte address. It drives the RAM's word port (we/addr/wdata, combinational rdata) and performs read-modify-write for sub-word stores, since the RAM writes whole words only. It returns sign- or zero-extended load data, and flags misaligned or illegal-size requests.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported, with 4 byte lanes.
BUS_WIDTH, 6, RAM word-index width; RAM depth is 2**BUS_WIDTH words.
ADDR_WIDTH, 32, CPU byte-address width; must be >= BUS_WIDTH+2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_err  out  1  qualified by resp_valid; misaligned or illegal size
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
mem_we  out  1  RAM write enable
mem_addr  out  BUS_WIDTH  RAM word index = addr_q[BUS_WIDTH+1:2]
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM combinational read data

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP, ERR.
- On accept, register we, size, signed, addr and wdata into *_q.
- Reset values (rst_n low at a clock edge):
  - State goes to IDLE, so req_ready=1 after reset.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is additionally gated by rst_n, so no RAM write occurs on an edge where rst_n=0.
  - A reset mid-operation abandons the transaction: no write and no response.
- Error check on accept:
  - Error if size=11, or if size=01 with addr[0]=1, or if size=10 with addr[1:0]!=0.
  - Error path: IDLE->ERR. ERR asserts resp_valid=1, resp_err=1 and resp_rdata=0 for one cycle, then returns to IDLE. mem_we is never asserted.
- Load: IDLE->READ->RESP->IDLE.
  - In READ, mem_addr is driven and mem_rdata is latched.
  - Lane select is little-endian: byte = lane addr_q[1:0], half = bits [16*addr_q[1] +: 16].
  - The selected lane is extended per signed_q into resp_rdata.
  - resp_valid is high in RESP.
  - Latency: accept at edge T, resp_valid high in cycle T+2.
- Word store: IDLE->WRITE->RESP->IDLE.
  - WRITE asserts mem_we=1 for exactly one cycle with mem_wdata=wdata_q.
  - resp_valid in cycle T+2, resp_rdata=0.
- Sub-word store: IDLE->READ->WRITE->RESP->IDLE.
  - READ latches the old word.
  - WRITE writes the merged word: the addressed lane(s) are replaced by wdata_q[7:0] or [15:0]; all other lanes are unchanged.
  - resp_valid in cycle T+3.
- mem_addr holds addr_q-derived index in all non-IDLE states. Upper address bits above BUS_WIDTH+1 are ignored, so addresses wrap modulo the RAM size.
- At most one outstanding request. req_valid while busy is not accepted, and the requester must hold it stable.
- A new request may be accepted in the cycle after RESP or ERR. IDLE is re-entered, so throughput is one request per 3 cycles (load or word store) or 4 cycles (sub-word store).
- mem_we is never high outside WRITE.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid sub-word store (state WRITE) -> no RAM write occurs; after release req_ready=1 and resp_valid=0, and the RAM word is unchanged.
- Word store then load: store 0xDEADBEEF to 0x08, then load word signed from 0x08 -> mem_we pulses once with mem_addr=2; load resp_rdata=0xDEADBEEF at T+2, resp_err=0.
- Byte store: with word 2 = 0x11223344, store byte 0xAB to 0x0A -> word 2 becomes 0x11AB3344; resp at T+3.
- Byte and halfword loads from word 2 = 0x11AB3344:
  - Signed byte load from 0x0A -> 0xFFFFFFAB.
  - Unsigned byte load from 0x0A -> 0x000000AB.
  - Signed halfword load from 0x0A -> 0x000011AB.
- Errors:
  - Word load at 0x06 -> resp_valid and resp_err at T+1, mem_we never high.
  - size=11 store -> same response, RAM unchanged.
- Wrap and backpressure:
  - Store word 0x5A5A5A5A at 0x100 with BUS_WIDTH=6 -> mem_addr=0.
  - Assert req_valid continuously while busy -> exactly one accept per completed transaction.
